// File: rtl/dcom_writer_pkg.sv
// rtl/dcom_writer_pkg.sv - shared types, constants and helpers for the DCOM data buffer writer
package dcom_writer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0] C_BE_FULL    = 8'hFF;
    localparam int         C_DATA_WIDTH = 64;

    // Byte lanes valid on the final word given len % 8; a zero remainder means a full word.
    function automatic logic [7:0] f_last_be(input logic [2:0] rem);
        return (rem == 3'd0) ? C_BE_FULL : ((8'h01 << rem) - 8'h01);
    endfunction

endpackage

// File: rtl/dcom_data_buffer_writer.sv
// rtl/dcom_data_buffer_writer.sv - Avalon-MM write master filling the DCOM data buffer from a stream
module dcom_data_buffer_writer
    import dcom_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clock_sink_clk,
    input  logic                    reset_sink_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_start_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_length_bytes,
    input  logic                    cmd_abort,
    input  logic                    stream_valid,
    output logic                    stream_ready,
    input  logic [C_DATA_WIDTH-1:0] stream_data,
    output logic [ADDR_WIDTH-1:0]   avm_data_buffer_address,
    output logic                    avm_data_buffer_write,
    output logic [C_DATA_WIDTH-1:0] avm_data_buffer_writedata,
    output logic [7:0]              avm_data_buffer_byteenable,
    input  logic                    avm_data_buffer_waitrequest,
    output logic                    status_busy,
    output logic                    status_done,
    output logic                    status_aborted,
    output logic [LEN_WIDTH-3:0]    status_words,
    output logic                    irq_done,
    input  logic                    irq_clear
);

    localparam int WW = LEN_WIDTH - 2;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]                be_q, be_d;
    logic [7:0]                last_be_q, last_be_d;
    logic [WW-1:0]             total_q, total_d;
    logic [WW-1:0]             words_q, words_d;
    logic                      abort_pend_q, abort_pend_d;
    logic                      aborted_q, aborted_d;
    logic                      write_q, busy_q, done_q, irq_q;

    logic [LEN_WIDTH:0]        len_plus;
    logic [WW-1:0]             words_inc;

    assign len_plus  = {1'b0, cmd_length_bytes} + (LEN_WIDTH+1)'(7);
    assign words_inc = words_q + 1'b1;

    assign cmd_ready    = (state_q == S_IDLE) && !reset_sink_reset;
    assign stream_ready = (state_q == S_LOAD) && !cmd_abort;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        be_d         = be_q;
        last_be_d    = last_be_q;
        total_d      = total_q;
        words_d      = words_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_start_addr;
                    total_d      = len_plus[LEN_WIDTH:3];
                    last_be_d    = f_last_be(cmd_length_bytes[2:0]);
                    words_d      = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = (cmd_length_bytes == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cmd_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (stream_valid) begin
                    data_d  = stream_data;
                    be_d    = (words_inc == total_q) ? last_be_q : C_BE_FULL;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // An abort here only takes effect once the in-flight write is accepted.
                if (cmd_abort) begin
                    abort_pend_d = 1'b1;
                end
                if (!avm_data_buffer_waitrequest) begin
                    words_d = words_inc;
                    addr_d  = addr_q + 1'b1;
                    if (words_inc == total_q || abort_pend_q || cmd_abort) begin
                        aborted_d = abort_pend_q || cmd_abort;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
            last_be_q    <= '0;
            total_q      <= '0;
            words_q      <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            be_q         <= be_d;
            last_be_q    <= last_be_d;
            total_q      <= total_d;
            words_q      <= words_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            write_q      <= (state_d == S_WRITE);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            // Set from DONE takes priority over a coincident clear.
            if (state_q == S_DONE) begin
                irq_q <= 1'b1;
            end else if (irq_clear) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign avm_data_buffer_address    = addr_q;
    assign avm_data_buffer_write      = write_q;
    assign avm_data_buffer_writedata  = data_q;
    assign avm_data_buffer_byteenable = be_q;
    assign status_busy                = busy_q;
    assign status_done                = done_q;
    assign status_aborted             = aborted_q;
    assign status_words               = words_q;
    assign irq_done                   = irq_q;

endmodule
